// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: command codes, FSM states and image geometry shared by lcd_ctrl and lcd_win_alu.
package lcd_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int IMG_DIM = 8;
  localparam int ADDR_W  = 6;
  localparam int NPIX    = IMG_DIM * IMG_DIM;

  localparam logic [2:0] INIT_X = 3'd4;
  localparam logic [2:0] INIT_Y = 3'd4;

  typedef enum logic [3:0] {
    CMD_WRITE = 4'd0,
    CMD_UP    = 4'd1,
    CMD_DOWN  = 4'd2,
    CMD_LEFT  = 4'd3,
    CMD_RIGHT = 4'd4,
    CMD_MAX   = 4'd5,
    CMD_MIN   = 4'd6,
    CMD_AVG   = 4'd7,
    CMD_CCW   = 4'd8,
    CMD_CW    = 4'd9,
    CMD_MIRX  = 4'd10,
    CMD_MIRY  = 4'd11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu: combinational 2x2 window operations (max, min, average, rotations).
// Mirror X/Y are only built when LCD_MIRROR_EN is defined; otherwise those codes pass pixels through.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
(
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] p0_i,
  input  logic [DATA_W-1:0] p1_i,
  input  logic [DATA_W-1:0] p2_i,
  input  logic [DATA_W-1:0] p3_i,
  output logic [DATA_W-1:0] p0_o,
  output logic [DATA_W-1:0] p1_o,
  output logic [DATA_W-1:0] p2_o,
  output logic [DATA_W-1:0] p3_o
);

  logic [DATA_W-1:0] max01, max23, max_all;
  logic [DATA_W-1:0] min01, min23, min_all;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] avg;

  assign max01   = (p0_i > p1_i) ? p0_i : p1_i;
  assign max23   = (p2_i > p3_i) ? p2_i : p3_i;
  assign max_all = (max01 > max23) ? max01 : max23;
  assign min01   = (p0_i < p1_i) ? p0_i : p1_i;
  assign min23   = (p2_i < p3_i) ? p2_i : p3_i;
  assign min_all = (min01 < min23) ? min01 : min23;

  // Ten bits hold the worst-case sum of four pixels; dropping two bits floors the divide by 4.
  assign sum = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
  assign avg = sum[DATA_W+1:2];

  always_comb begin
    p0_o = p0_i;
    p1_o = p1_i;
    p2_o = p2_i;
    p3_o = p3_i;
    case (cmd_i)
      CMD_MAX: begin p0_o = max_all; p1_o = max_all; p2_o = max_all; p3_o = max_all; end
      CMD_MIN: begin p0_o = min_all; p1_o = min_all; p2_o = min_all; p3_o = min_all; end
      CMD_AVG: begin p0_o = avg;     p1_o = avg;     p2_o = avg;     p3_o = avg;     end
      CMD_CCW: begin p0_o = p1_i; p1_o = p3_i; p3_o = p2_i; p2_o = p0_i; end
      CMD_CW:  begin p0_o = p2_i; p1_o = p0_i; p3_o = p1_i; p2_o = p3_i; end
`ifdef LCD_MIRROR_EN
      CMD_MIRX: begin p0_o = p2_i; p2_o = p0_i; p1_o = p3_i; p3_o = p1_i; end
      CMD_MIRY: begin p0_o = p1_i; p1_o = p0_i; p2_o = p3_i; p3_o = p2_i; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: loads an 8x8 frame from IROM, runs host window commands, dumps the frame to IRAM.
// Build option LCD_MIRROR_EN enables the mirror commands inside lcd_win_alu.
//   state | meaning
//   LOAD  | read IROM 0..63 into the pixel buffer (one cycle read latency)
//   IDLE  | busy low, waiting for cmd_valid
//   EXEC  | apply latched command to point/window for one cycle
//   WRITE | stream buffer to IRAM 0..63
//   DONE  | done and busy held until reset
module lcd_ctrl
  import lcd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic              rom_rd_q;
  logic [ADDR_W-1:0] rom_a_q;
  logic              ram_valid_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [DATA_W-1:0] ram_d_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        cmd_q;
  logic [2:0]        x_q, y_q, x_d, y_d;
  logic [DATA_W-1:0] pix_q [NPIX];

  logic [2:0]        xm1, ym1;
  logic [ADDR_W-1:0] a0, a1, a2, a3, ram_a_nxt;
  logic [DATA_W-1:0] n0, n1, n2, n3;

  assign xm1       = x_q - 3'd1;
  assign ym1       = y_q - 3'd1;
  assign a0        = pix_addr(ym1, xm1);
  assign a1        = pix_addr(ym1, x_q);
  assign a2        = pix_addr(y_q, xm1);
  assign a3        = pix_addr(y_q, x_q);
  assign ram_a_nxt = ram_a_q + 1'b1;

  lcd_win_alu u_alu (
    .cmd_i (cmd_q),
    .p0_i  (pix_q[a0]),
    .p1_i  (pix_q[a1]),
    .p2_i  (pix_q[a2]),
    .p3_i  (pix_q[a3]),
    .p0_o  (n0),
    .p1_o  (n1),
    .p2_o  (n2),
    .p3_o  (n3)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (cmd_q)
      CMD_UP:    if (y_q > 3'd1) y_d = y_q - 3'd1;
      CMD_DOWN:  if (y_q < 3'd7) y_d = y_q + 3'd1;
      CMD_LEFT:  if (x_q > 3'd1) x_d = x_q - 3'd1;
      CMD_RIGHT: if (x_q < 3'd7) x_d = x_q + 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= '0;
      ram_valid_q <= 1'b0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      cmd_q       <= '0;
      x_q         <= INIT_X;
      y_q         <= INIT_Y;
      for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          rom_rd_q <= 1'b1;
          // Data for rom_a_q arrives one cycle after the address was presented.
          if (rom_rd_q) begin
            pix_q[rom_a_q] <= IROM_Q;
            if (rom_a_q == ADDR_W'(NPIX - 1)) begin
              rom_rd_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              rom_a_q <= rom_a_q + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q   <= cmd;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cmd_q == CMD_WRITE) begin
            ram_valid_q <= 1'b1;
            ram_a_q     <= '0;
            ram_d_q     <= pix_q[0];
            state_q     <= ST_WRITE;
          end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q[a0] <= n0;
            pix_q[a1] <= n1;
            pix_q[a2] <= n2;
            pix_q[a3] <= n3;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (ram_a_q == ADDR_W'(NPIX - 1)) begin
            ram_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            ram_a_q <= ram_a_nxt;
            ram_d_q <= pix_q[ram_a_nxt];
          end
        end
        ST_DONE: ;
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign IROM_rd    = rom_rd_q;
  assign IROM_A     = rom_a_q;
  assign IRAM_valid = ram_valid_q;
  assign IRAM_A     = ram_a_q;
  assign IRAM_D     = ram_d_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: randomized and directed checks of lcd_ctrl against a pixel-array reference model.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q = 8'd0;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  lcd_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IROM_Q     (IROM_Q),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom   [64];
  logic [7:0] ram   [64];
  logic [7:0] model [64];
  int px, py;
  int wr_cnt = 0;
  int wr_order_bad = 0;

  // External memories: both act on the falling edge.
  always @(negedge clk) begin
    if (IROM_rd) IROM_Q = rom[IROM_A];
    if (IRAM_valid) begin
      if (int'(IRAM_A) != wr_cnt) wr_order_bad++;
      ram[IRAM_A] = IRAM_D;
      wr_cnt++;
    end
  end

  task automatic fill_rom();
    for (int k = 0; k < 64; k++) rom[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic reset_load(output int lat);
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 64; k++) model[k] = rom[k];
    px = 4;
    py = 4;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (!busy) begin lat = n; break; end
    end
    @(negedge clk);
  endtask

  // Reference behaviour of one non-write command on the pixel array.
  task automatic model_apply(input int c);
    int w [4];
    int p [4];
    int s;
    w[0] = (py - 1) * 8 + px - 1;
    w[1] = (py - 1) * 8 + px;
    w[2] = py * 8 + px - 1;
    w[3] = py * 8 + px;
    for (int k = 0; k < 4; k++) p[k] = int'(model[w[k]]);
    case (c)
      1: if (py > 1) py--;
      2: if (py < 7) py++;
      3: if (px > 1) px--;
      4: if (px < 7) px++;
      5: begin s = p[0]; for (int k = 1; k < 4; k++) if (p[k] > s) s = p[k];
               for (int k = 0; k < 4; k++) model[w[k]] = 8'(s); end
      6: begin s = p[0]; for (int k = 1; k < 4; k++) if (p[k] < s) s = p[k];
               for (int k = 0; k < 4; k++) model[w[k]] = 8'(s); end
      7: begin s = (p[0] + p[1] + p[2] + p[3]) / 4;
               for (int k = 0; k < 4; k++) model[w[k]] = 8'(s); end
      8: begin model[w[0]] = 8'(p[1]); model[w[1]] = 8'(p[3]);
               model[w[3]] = 8'(p[2]); model[w[2]] = 8'(p[0]); end
      9: begin model[w[0]] = 8'(p[2]); model[w[1]] = 8'(p[0]);
               model[w[3]] = 8'(p[1]); model[w[2]] = 8'(p[3]); end
`ifdef LCD_MIRROR_EN
      10: begin model[w[0]] = 8'(p[2]); model[w[2]] = 8'(p[0]);
                model[w[1]] = 8'(p[3]); model[w[3]] = 8'(p[1]); end
      11: begin model[w[0]] = 8'(p[1]); model[w[1]] = 8'(p[0]);
                model[w[2]] = 8'(p[3]); model[w[3]] = 8'(p[2]); end
`endif
      default: ;
    endcase
  endtask

  // Entered at a falling edge with busy low; returns at a falling edge.
  task automatic send(input int c);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    model_apply(c);
  endtask

  task automatic write_dump(output int lat);
    wr_cnt = 0;
    wr_order_bad = 0;
    for (int k = 0; k < 64; k++) ram[k] = 8'hxx;
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if ({IROM_rd, IROM_A} !== 7'd0) begin bad++; $display("FAIL reset_irom got rd=%b a=%0d want 0/0", IROM_rd, IROM_A); end
    total++; if ({IRAM_valid, IRAM_A, IRAM_D} !== 15'd0) begin bad++;
      $display("FAIL reset_iram got v=%b a=%0d d=%0d want 0/0/0", IRAM_valid, IRAM_A, IRAM_D); end
  endtask

  task automatic test_load_and_copy();
    int lat;
    fill_rom();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      total++;
      if (IROM_rd !== 1'b1 || int'(IROM_A) != n - 1 || busy !== 1'b1) begin bad++;
        $display("FAIL load_step%0d got rd=%b a=%0d busy=%b want 1/%0d/1", n, IROM_rd, IROM_A, busy, n - 1); end
    end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || IROM_rd !== 1'b0) begin bad++;
      $display("FAIL load_end got busy=%b rd=%b want 0/0", busy, IROM_rd); end
    @(negedge clk);
    write_dump(lat);
    total++; if (lat != 65) begin bad++; $display("FAIL copy_done_lat got=%0d want=65", lat); end
    total++; if (wr_cnt != 64 || wr_order_bad != 0) begin bad++;
      $display("FAIL copy_writes got cnt=%0d misorder=%0d want 64/0", wr_cnt, wr_order_bad); end
    for (int k = 0; k < 64; k++) begin
      total++; if (ram[k] !== rom[k]) begin bad++; $display("FAIL copy_pix%0d got=%0d want=%0d", k, ram[k], rom[k]); end
    end
  endtask

  task automatic test_window_ops();
    int lat;
    int ops [7] = '{7, 5, 6, 8, 9, 10, 11};
    int ex [7][4] = '{'{25, 25, 25, 25}, '{41, 41, 41, 41}, '{10, 10, 10, 10},
                      '{20, 41, 10, 30}, '{30, 10, 41, 20},
`ifdef LCD_MIRROR_EN
                      '{30, 41, 10, 20}, '{20, 10, 41, 30}
`else
                      '{10, 20, 30, 41}, '{10, 20, 30, 41}
`endif
                     };
    int wa [4] = '{27, 28, 35, 36};
    int want;
    for (int i = 0; i < 7; i++) begin
      fill_rom();
      rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd41;
      reset_load(lat);
      total++; if (lat != 65) begin bad++; $display("FAIL win%0d_load_lat got=%0d want=65", ops[i], lat); end
      send(ops[i]);
      write_dump(lat);
      for (int k = 0; k < 64; k++) begin
        want = int'(rom[k]);
        for (int j = 0; j < 4; j++) if (k == wa[j]) want = ex[i][j];
        total++; if (ram[k] !== 8'(want)) begin bad++;
          $display("FAIL win_cmd%0d_pix%0d got=%0d want=%0d", ops[i], k, ram[k], want); end
      end
    end
  endtask

  task automatic test_boundary();
    int lat;
    int mx;
    int want;
    fill_rom();
    reset_load(lat);
    repeat (5) send(3);
    repeat (5) send(1);
    send(5);
    write_dump(lat);
    mx = int'(rom[0]);
    if (int'(rom[1]) > mx) mx = int'(rom[1]);
    if (int'(rom[8]) > mx) mx = int'(rom[8]);
    if (int'(rom[9]) > mx) mx = int'(rom[9]);
    for (int k = 0; k < 64; k++) begin
      want = (k == 0 || k == 1 || k == 8 || k == 9) ? mx : int'(rom[k]);
      total++; if (ram[k] !== 8'(want)) begin bad++; $display("FAIL corner_pix%0d got=%0d want=%0d", k, ram[k], want); end
    end
  endtask

  task automatic test_handshake();
    int lat;
    int c;
    fill_rom();
    reset_load(lat);
    for (int i = 0; i < 10; i++) begin
      c = (i == 9) ? 4 : int'($urandom_range(1, 15));
      cmd = 4'(c);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hs_accept%0d got busy=%b want=1", i, busy); end
      // Last iteration keeps cmd_valid high through the busy cycle; it must not be accepted twice.
      if (i != 9) cmd_valid = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_release%0d got busy=%b want=0", i, busy); end
      model_apply(c);
      @(negedge clk);
    end
    send(5);
    write_dump(lat);
    for (int k = 0; k < 64; k++) begin
      total++; if (ram[k] !== model[k]) begin bad++; $display("FAIL hs_pix%0d got=%0d want=%0d", k, ram[k], model[k]); end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int s = 0; s < 6; s++) begin
      fill_rom();
      reset_load(lat);
      for (int i = 0; i < 25; i++) send(int'($urandom_range(1, 15)));
      write_dump(lat);
      total++; if (lat != 65) begin bad++; $display("FAIL rnd%0d_done_lat got=%0d want=65", s, lat); end
      for (int k = 0; k < 64; k++) begin
        total++; if (ram[k] !== model[k]) begin bad++;
          $display("FAIL rnd%0d_pix%0d got=%0d want=%0d", s, k, ram[k], model[k]); end
      end
    end
  endtask

  // Called right after a completed dump: DONE must hold and ignore commands.
  task automatic test_done_hold();
    for (int i = 0; i < 4; i++) begin
      cmd = 4'(i + 1);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (done !== 1'b1 || busy !== 1'b1 || IRAM_valid !== 1'b0) begin bad++;
        $display("FAIL done_hold%0d got done=%b busy=%b v=%b want 1/1/0", i, done, busy, IRAM_valid); end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat;
    fill_rom();
    reset_load(lat);
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (IRAM_valid !== 1'b1) begin bad++; $display("FAIL midwr_active got v=%b want=1", IRAM_valid); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (IRAM_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || IROM_rd !== 1'b0 || IROM_A !== 6'd0) begin bad++;
      $display("FAIL midwr_abort got v=%b busy=%b done=%b rd=%b a=%0d want 0/1/0/0/0",
               IRAM_valid, busy, done, IROM_rd, IROM_A); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 64; k++) model[k] = rom[k];
    @(posedge clk); #1;
    total++; if (IROM_rd !== 1'b1 || IROM_A !== 6'd0) begin bad++;
      $display("FAIL midwr_restart got rd=%b a=%0d want 1/0", IROM_rd, IROM_A); end
    lat = -1;
    for (int n = 2; n <= 300; n++) begin
      @(posedge clk); #1;
      if (!busy) begin lat = n; break; end
    end
    total++; if (lat != 65) begin bad++; $display("FAIL midwr_reload_lat got=%0d want=65", lat); end
    @(negedge clk);
    write_dump(lat);
    for (int k = 0; k < 64; k++) begin
      total++; if (ram[k] !== rom[k]) begin bad++; $display("FAIL midwr_pix%0d got=%0d want=%0d", k, ram[k], rom[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_copy();
    test_done_hold();
    test_window_ops();
    test_boundary();
    test_handshake();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Image-display controller for an 8x8 frame of 8-bit pixels.
- After reset it loads the whole frame from an external instruction ROM (IROM) into an internal 64-entry pixel buffer.
- It then executes host commands on a 2x2 window centred on a movable operation point.
- On a Write command it streams the buffer to an external RAM (IRAM) and asserts done.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_DIM, 8, image side length (64 pixels; addresses are 6 bits).

Ports:
- clk  in  1  single system clock; all DUT registers update on rising edge.
- reset  in  1  asynchronous active-low reset.
- cmd  in  4  command code, sampled when cmd_valid=1 and busy=0.
- cmd_valid  in  1  command strobe.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  6  ROM address.
- IROM_Q  in  8  ROM data; ROM updates it on the falling clk edge while IROM_rd=1.
- IRAM_valid  out  1  RAM write enable; RAM writes on the falling edge.
- IRAM_D  out  8  RAM write data.
- IRAM_A  out  6  RAM write address.
- busy  out  1  high while loading or executing; commands are ignored while high.
- done  out  1  high once the Write dump has completed.

Behaviour:
- Reset (reset=0): all registers clear.
  - busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0.
  - Operation point is set to (x=4, y=4). FSM enters LOAD.
- Address map: pixel address = row*8 + col.
- 2x2 window at point (x,y):
  - P0 = (row y-1, col x-1), P1 = (y-1, x), P2 = (y, x-1), P3 = (y, x).
  - x and y each range 1..7.
- States: LOAD -> IDLE -> EXEC -> IDLE; and IDLE -> WRITE -> DONE.
- LOAD:
  - IROM_rd=1; IROM_A sweeps 0..63, one address per cycle.
  - IROM_Q for an address is captured on the rising edge after the ROM's falling-edge update, i.e. pipeline latency 1 cycle.
  - After pixel 63 is stored: IROM_rd=0, busy=0, go to IDLE.
- IDLE, busy=0:
  - On a rising edge with cmd_valid=1, latch cmd and set busy=1 on that same edge.
  - The host sees busy high at the next falling edge.
- EXEC: one cycle, buffer/point updated, then busy=0 and return to IDLE. Commands:
  - 0 Write: go to WRITE.
  - 1 Up: y-1 if y>1. 2 Down: y+1 if y<7. 3 Left: x-1 if x>1. 4 Right: x+1 if x<7. At the boundary the point does not move.
  - 5 Max: P0..P3 all set to their maximum.
  - 6 Min: P0..P3 all set to their minimum.
  - 7 Average: all four set to floor((P0+P1+P2+P3)/4). The sum uses a 10-bit accumulator.
  - 8 CCW rotate: P0<=P1, P1<=P3, P3<=P2, P2<=P0.
  - 9 CW rotate: P0<=P2, P1<=P0, P3<=P1, P2<=P3.
  - 10 Mirror X: swap P0<->P2 and P1<->P3.
  - 11 Mirror Y: swap P0<->P1 and P2<->P3.
  - 12-15: no operation, 1 busy cycle.
  - All window writes use pre-command values (simultaneous update).
- WRITE:
  - IRAM_valid=1; IRAM_A = 0..63, one per cycle; IRAM_D = buffer[IRAM_A].
  - After address 63 has been presented: IRAM_valid=0 and done=1 on the next rising edge, so done rises after the final falling-edge write. Then enter DONE.
- DONE: done=1 and busy=1 held until reset; further cmd_valid is ignored.
- Reset mid-operation: aborts immediately, returns to the reset values above, and LOAD restarts from address 0.

Optional Feature:
- Macro LCD_MIRROR_EN.
- Defined: commands 10/11 perform Mirror X / Mirror Y as specified.
- Undefined: commands 10/11 are no-ops (1 busy cycle, no buffer change) and the swap logic is not synthesized.

Decomposition:
- Package lcd_ctrl_pkg holds:
  - command codes (CMD_WRITE=0 ... CMD_MIRY=11);
  - FSM state enum (LOAD, IDLE, EXEC, WRITE, DONE);
  - constants IMG_DIM=8, INIT_X=4, INIT_Y=4, ADDR_W=6.
- One natural sub-module: lcd_win_alu. It is combinational: takes P0..P3 and cmd, returns new P0..P3 for commands 5-11.

Test Plan:
- Reset then idle:
  - IROM_A steps 0..63 with IROM_rd=1; busy falls after 64+1 cycles.
  - cmd 0 -> IRAM holds an exact copy of the ROM; done rises.
- Window at (4,4) with P0=10, P1=20, P2=30, P3=41:
  - cmd 7 -> all four = 25.
  - cmd 5 -> all four = 41; cmd 6 -> all four = 10.
- Same window:
  - cmd 8 -> P0=20, P1=41, P2=10, P3=30.
  - cmd 9 from the original -> P0=30, P1=10, P2=41, P3=20.
- Boundary: cmd 3 issued 5 times then cmd 1 issued 5 times -> point (1,1); a Max then affects only addresses 0, 1, 8, 9.
- Mirror with LCD_MIRROR_EN:
  - cmd 10 on the window above -> P0=30, P2=10, P1=41, P3=20.
  - Without the macro -> buffer unchanged.
- Handshake and reset:
  - Every accepted cmd raises busy at the accepting edge; busy is low exactly one cycle later.
  - Asserting reset=0 mid-WRITE aborts the dump and restarts LOAD from address 0.
